fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the main controller and decoder.
- Owns the PC and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO and presents instr/pc/opcode to decode with a valid/ready handshake.
- Accepts redirects from branch/jump resolution: flushes buffered instructions and drops stale in-flight responses.

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage feeding the controller/decoder.
// Owns the PC, issues word requests to instruction memory, buffers returned
// words in a small FIFO tagged with their PC, and hands them to decode over a
// valid/ready handshake. A redirect flushes the buffer, retargets the PC and
// arranges for responses already in flight to be thrown away on arrival.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   imem_req_valid_o/ready_i  fetch request handshake
//   imem_req_addr_o           word-aligned fetch address (the current PC)
//   imem_resp_valid_i/data_i  in-order responses, one per accepted request
//   redirect_i/redirect_pc_i  single-cycle redirect strobe and its target
//   instr_valid_o/ready_i     decode handshake
//   instr_o/pc_o/opcode_o     head instruction, its PC and its opcode field
//   fetch_misalign_o          sticky flag: some redirect target was misaligned
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode_o,
  output logic        fetch_misalign_o
);

  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic [31:0]   pc_q;
  logic [31:0]   resp_pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] discard_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic          misalign_q;
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem    [FIFO_DEPTH];

  logic          fifo_empty;
  logic          instr_valid;
  logic          pop;
  logic [CW:0]   credit_used;
  logic          req_valid;
  logic          req_fire;
  logic          resp_accept;
  logic          resp_drop;
  logic          push;
  logic [CW-1:0] outstanding_after_resp;
  logic [31:0]   redirect_target;

  // Handshake and credit decisions for this cycle.
  // Credit covers every word we might still have to hold: requests in flight
  // plus buffered entries. An entry popped this cycle frees its slot at once,
  // which lets a 1-cycle memory stream one word per cycle through a 2-deep
  // buffer. Since a kept response always retires an outstanding request, a
  // push can never land in a full buffer.
  // A response with nothing outstanding is treated as noise and ignored.
  always_comb begin
    fifo_empty             = (count_q == '0);
    instr_valid            = !rst_i && !fifo_empty && !redirect_i;
    pop                    = instr_valid && instr_ready_i;
    credit_used            = {1'b0, outstanding_q} + {1'b0, count_q} - (CW+1)'(pop);
    req_valid              = !rst_i && !redirect_i && (credit_used < CREDIT_MAX);
    req_fire               = req_valid && imem_req_ready_i;
    resp_accept            = !rst_i && imem_resp_valid_i && (outstanding_q != '0);
    resp_drop              = resp_accept && (redirect_i || (discard_q != '0));
    push                   = resp_accept && !resp_drop;
    outstanding_after_resp = outstanding_q - CW'(resp_accept);
    redirect_target        = {redirect_pc_i[31:2], 2'b00};
  end

  // Control state: PC, response PC, in-flight/discard counters, FIFO pointers.
  // A redirect wins over everything except reset. Whatever is still in flight
  // after this cycle's response becomes the number of responses to discard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      misalign_q    <= 1'b0;
    end else if (redirect_i) begin
      pc_q          <= redirect_target;
      resp_pc_q     <= redirect_target;
      outstanding_q <= outstanding_after_resp;
      discard_q     <= outstanding_after_resp;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        misalign_q <= 1'b1;
      end
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + 32'd4;
      end
      outstanding_q <= outstanding_after_resp + CW'(req_fire);
      if (resp_drop && (discard_q != '0)) begin
        discard_q <= discard_q - CW'(1);
      end
      if (push) begin
        resp_pc_q <= resp_pc_q + 32'd4;
        wr_ptr_q  <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage; contents need no reset because the count guards reads.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_resp_data_i;
      pc_mem[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // With an empty buffer decode sees a NOP tagged with the fetch PC.
  always_comb begin
    imem_req_valid_o = req_valid;
    imem_req_addr_o  = pc_q;
    instr_valid_o    = instr_valid;
    instr_o          = fifo_empty ? NOP : instr_mem[rd_ptr_q];
    pc_o             = fifo_empty ? pc_q : pc_mem[rd_ptr_q];
    opcode_o         = instr_o[6:0];
    fetch_misalign_o = misalign_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Randomized bench for fetch_unit. A queue-based reference model tracks the
// fetch address, requests in flight (each tagged stale once a redirect passes
// it) and the decode buffer; every cycle all DUT outputs are compared with it.
// Directed phases cover streaming, decode stall, redirect with stale
// responses, misaligned/wrapping redirects and reset mid-operation.
module tb_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic        fetch_misalign_o;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .opcode_o(opcode_o),
    .fetch_misalign_o(fetch_misalign_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  req_t        inflight[$];
  ent_t        fifo_q[$];
  logic [31:0] m_pc = RST_PC;
  bit          m_misalign = 1'b0;
  bit          started = 1'b0;
  int          cyc = 0;

  int lat_min = 1, lat_max = 1;
  int mem_rdy_pct = 100, dec_rdy_pct = 100, resp_stall_pct = 0;
  int redir_pct = 0, spur_pct = 0, rst_pct = 0, mis_pct = 0;
  bit          rst_hold = 1'b1;
  bit          force_redir = 1'b0;
  logic [31:0] force_target = '0;

  logic [31:0] acc_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_instr_log[$];
  int          pop_cyc_log[$];

  int checks_total  = 0;
  int checks_passed = 0;

  // Memory contents: a scrambled function of the address so opcodes vary.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    if ($urandom_range(99) < 20) t = 32'hFFFF_FFE0 + ($urandom_range(7) << 2);
    else                         t = $urandom_range(255) << 2;
    if ($urandom_range(99) < mis_pct) t = t | 32'($urandom_range(3, 1));
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    else checks_passed++;
  endtask

  // One cycle per iteration: drive inputs at negedge, compare outputs with
  // the model, then advance the model on the rising edge.
  task automatic applyStimulus(input int n);
    bit   exp_ivalid, exp_pop, exp_rvalid;
    req_t r;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_i);
      rst_i = rst_hold || ($urandom_range(99) < rst_pct);
      if (force_redir) begin
        redirect_i    = 1'b1;
        redirect_pc_i = force_target;
        force_redir   = 1'b0;
      end else begin
        redirect_i    = ($urandom_range(99) < redir_pct);
        redirect_pc_i = pick_target();
      end
      imem_req_ready_i  = ($urandom_range(99) < mem_rdy_pct);
      instr_ready_i     = ($urandom_range(99) < dec_rdy_pct);
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = $urandom;
      if (inflight.size() > 0) begin
        if (cyc >= inflight[0].due && $urandom_range(99) >= resp_stall_pct) begin
          imem_resp_valid_i = 1'b1;
          imem_resp_data_i  = mem_word(inflight[0].addr);
        end
      end else if ($urandom_range(99) < spur_pct) begin
        imem_resp_valid_i = 1'b1;
      end
      #1;
      exp_ivalid = !rst_i && (fifo_q.size() > 0) && !redirect_i;
      exp_pop    = exp_ivalid && instr_ready_i;
      exp_rvalid = !rst_i && !redirect_i &&
                   ((inflight.size() + fifo_q.size() - int'(exp_pop)) < DEPTH);
      if (started) begin
        checkOutput("req_valid", imem_req_valid_o, exp_rvalid);
        checkOutput("req_addr", imem_req_addr_o, m_pc);
        checkOutput("instr_valid", instr_valid_o, exp_ivalid);
        checkOutput("instr", instr_o, (fifo_q.size() > 0) ? fifo_q[0].instr : NOP);
        checkOutput("pc", pc_o, (fifo_q.size() > 0) ? fifo_q[0].pc : m_pc);
        checkOutput("opcode", opcode_o, (fifo_q.size() > 0) ? fifo_q[0].instr[6:0] : NOP[6:0]);
        checkOutput("misalign", fetch_misalign_o, m_misalign);
      end
      if (instr_valid_o && instr_ready_i) begin
        pop_pc_log.push_back(pc_o);
        pop_instr_log.push_back(instr_o);
        pop_cyc_log.push_back(cyc);
      end
      @(posedge clk_i);
      if (rst_i) begin
        inflight.delete();
        fifo_q.delete();
        m_pc       = RST_PC;
        m_misalign = 1'b0;
        started    = 1'b1;
      end else begin
        if (exp_pop) void'(fifo_q.pop_front());
        if (imem_resp_valid_i && inflight.size() > 0) begin
          r = inflight.pop_front();
          if (!r.stale && !redirect_i) fifo_q.push_back('{mem_word(r.addr), r.addr});
        end
        if (redirect_i) begin
          fifo_q.delete();
          foreach (inflight[i]) inflight[i].stale = 1'b1;
          m_pc = {redirect_pc_i[31:2], 2'b00};
          if (redirect_pc_i[1:0] != 2'b00) m_misalign = 1'b1;
        end else if (exp_rvalid && imem_req_ready_i) begin
          inflight.push_back('{m_pc, 1'b0, cyc + $urandom_range(lat_max, lat_min)});
          acc_log.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
      cyc++;
    end
  endtask

  task automatic clearLogs();
    acc_log.delete();
    pop_pc_log.delete();
    pop_instr_log.delete();
    pop_cyc_log.delete();
  endtask

  initial begin
    int breaks;
    int start_cyc;
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_req_ready_i = 1'b0; instr_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0; imem_resp_data_i = '0;

    // Reset, then stream with a 1-cycle memory and an always-ready decoder.
    applyStimulus(3);
    rst_hold = 1'b0;
    clearLogs();
    start_cyc = cyc;
    applyStimulus(22);
    checkOutput("stream_reqs", acc_log.size(), 22);
    checkOutput("stream_pops", pop_pc_log.size(), 20);
    if (pop_pc_log.size() > 0) begin
      checkOutput("first_pop_pc", pop_pc_log[0], RST_PC);
      checkOutput("first_pop_cycle", pop_cyc_log[0] - start_cyc, 2);
    end

    // Decode stall for 10 cycles, then resume with no lost/duplicated PC.
    acc_log.delete();
    dec_rdy_pct = 0;
    applyStimulus(10);
    checkOutput("stall_reqs_le2", acc_log.size() <= 2, 1);
    #1;
    checkOutput("stall_req_low", imem_req_valid_o, 0);
    dec_rdy_pct = 100;
    applyStimulus(10);
    breaks = 0;
    for (int i = 1; i < pop_pc_log.size(); i++)
      if (pop_pc_log[i] != pop_pc_log[i-1] + 32'd4) breaks++;
    checkOutput("pc_contiguous", breaks, 0);

    // 3-cycle memory, two requests in flight, redirect to 0x100.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 12 && inflight.size() != 2; k++) applyStimulus(1);
    #1;
    checkOutput("credit_full_req_low", imem_req_valid_o, 0);
    force_redir = 1'b1; force_target = 32'h0000_0100;
    applyStimulus(1);
    clearLogs();
    applyStimulus(14);
    checkOutput("redir_pops_seen", pop_pc_log.size() > 0, 1);
    if (pop_pc_log.size() > 0) begin
      checkOutput("redir_first_pc", pop_pc_log[0], 32'h0000_0100);
      checkOutput("redir_first_instr", pop_instr_log[0], mem_word(32'h0000_0100));
    end

    // Redirect in the same cycle as a response and a ready decoder.
    lat_min = 1; lat_max = 1;
    applyStimulus(8);
    force_redir = 1'b1; force_target = 32'h0000_0040;
    applyStimulus(1);
    #1;
    checkOutput("redir_pc_q", imem_req_addr_o, 32'h0000_0040);
    checkOutput("redir_flush_instr", instr_o, NOP);
    checkOutput("redir_flush_pc", pc_o, 32'h0000_0040);

    // Misaligned redirect, sticky flag, then wrap at the top of memory.
    applyStimulus(3);
    force_redir = 1'b1; force_target = 32'h0000_0202;
    applyStimulus(1);
    #1;
    checkOutput("misalign_addr", imem_req_addr_o, 32'h0000_0200);
    checkOutput("misalign_set", fetch_misalign_o, 1);
    redir_pct = 10;
    applyStimulus(20);
    redir_pct = 0;
    #1;
    checkOutput("misalign_sticky", fetch_misalign_o, 1);
    force_redir = 1'b1; force_target = 32'hFFFF_FFFC;
    applyStimulus(1);
    acc_log.delete();
    applyStimulus(6);
    checkOutput("wrap_reqs", acc_log.size() >= 2, 1);
    if (acc_log.size() >= 2) begin
      checkOutput("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
      checkOutput("wrap_addr1", acc_log[1], 32'h0000_0000);
    end

    // Reset mid-operation with a full buffer.
    dec_rdy_pct = 0;
    applyStimulus(6);
    rst_hold = 1'b1;
    applyStimulus(1);
    #1;
    checkOutput("rst_req_valid", imem_req_valid_o, 0);
    checkOutput("rst_instr_valid", instr_valid_o, 0);
    checkOutput("rst_addr", imem_req_addr_o, RST_PC);
    checkOutput("rst_instr", instr_o, NOP);
    checkOutput("rst_misalign", fetch_misalign_o, 0);
    rst_hold = 1'b0; dec_rdy_pct = 100;
    acc_log.delete();
    applyStimulus(4);
    checkOutput("restart_reqs", acc_log.size() > 0, 1);
    if (acc_log.size() > 0) checkOutput("restart_addr", acc_log[0], RST_PC);

    // Randomized segments with varying latency, back-pressure and redirects.
    for (int seg = 0; seg < 20; seg++) begin
      lat_min        = $urandom_range(2, 1);
      lat_max        = lat_min + $urandom_range(3);
      mem_rdy_pct    = $urandom_range(100, 30);
      dec_rdy_pct    = $urandom_range(100, 30);
      resp_stall_pct = $urandom_range(30);
      redir_pct      = $urandom_range(8);
      spur_pct       = 10;
      rst_pct        = (seg % 5 == 4) ? 2 : 0;
      mis_pct        = (seg % 4 == 3) ? 30 : 0;
      applyStimulus(150);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
